// File: rtl/wb_shared_bus.sv
// wb_shared_bus
//   Wishbone B4 classic shared bus. Arbitrates the core instruction bus (ibus)
//   and data bus (dbus) onto NUM_SLAVES slaves selected by address decode.
//   Ownership is round-robin, and a master keeps the bus for as long as its
//   cyc stays high. Accesses that match no slave get a one-cycle error. An
//   optional timeout produces an error when a slave never responds.
//
//   Optional feature macro: WB_BUS_TIMEOUT_EN
//     defined   : a timeout counter forces err after TIMEOUT_CYCLES stalled cycles.
//     undefined : there is no counter, so a non-acking slave stalls the bus.
//
// Ports
//   wb_clk, wb_rst          bus clock, asynchronous active-high reset
//   wb_ibus_*               instruction master (read-only): adr/cyc/stb in, rdt/ack/err out
//   wb_dbus_*               data master: adr/dat/sel/we/cyc/stb in, rdt/ack/err out
//   wbs_adr/dat/sel/we      address/data/select/write-enable broadcast to every slave
//   wbs_cyc/stb             per-slave cycle and strobe
//   wbs_rdt/ack             per-slave read data (slave i at [32*i+:32]) and ack
//
// Owner FSM
//   state     | meaning
//   OWN_NONE  | bus idle; grants on the next edge any master that has cyc high
//   OWN_IBUS  | ibus owns the bus until its cyc drops
//   OWN_DBUS  | dbus owns the bus until its cyc drops
module wb_shared_bus #(
  parameter int                       NUM_SLAVES     = 4,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE     = {32'h8000_0000, 32'h4000_0000,
                                                        32'h1000_0000, 32'h0000_0000},
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK     = {NUM_SLAVES{32'hF000_0000}},
  parameter int                       TIMEOUT_CYCLES = 255
) (
  input  logic                       wb_clk,
  input  logic                       wb_rst,
  input  logic [31:0]                wb_ibus_adr,
  input  logic                       wb_ibus_cyc,
  input  logic                       wb_ibus_stb,
  output logic [31:0]                wb_ibus_rdt,
  output logic                       wb_ibus_ack,
  output logic                       wb_ibus_err,
  input  logic [31:0]                wb_dbus_adr,
  input  logic [31:0]                wb_dbus_dat,
  input  logic [3:0]                 wb_dbus_sel,
  input  logic                       wb_dbus_we,
  input  logic                       wb_dbus_cyc,
  input  logic                       wb_dbus_stb,
  output logic [31:0]                wb_dbus_rdt,
  output logic                       wb_dbus_ack,
  output logic                       wb_dbus_err,
  output logic [31:0]                wbs_adr,
  output logic [31:0]                wbs_dat,
  output logic [3:0]                 wbs_sel,
  output logic                       wbs_we,
  output logic [NUM_SLAVES-1:0]      wbs_cyc,
  output logic [NUM_SLAVES-1:0]      wbs_stb,
  input  logic [32*NUM_SLAVES-1:0]   wbs_rdt,
  input  logic [NUM_SLAVES-1:0]      wbs_ack
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IBUS = 2'd1;
  localparam logic [1:0] OWN_DBUS = 2'd2;

  logic [1:0]    owner, owner_nxt;
  logic          last_dbus;

  logic          own_cyc, own_stb, own_we;
  logic [31:0]   own_adr, own_dat;
  logic [3:0]    own_sel;

  logic          hit_any;
  logic [IW-1:0] slv_idx;
  logic          ack_int, err_int;
  logic          miss_err_q;
  logic          to_fire;
  logic [31:0]   rdt_sel;

  // Owner FSM: a bus that has just been released always spends one cycle in
  // OWN_NONE before it is granted again, which gives the idle gap between owners.
  always_comb begin
    owner_nxt = owner;
    case (owner)
      OWN_NONE: begin
        if (wb_dbus_cyc && (!wb_ibus_cyc || !last_dbus))
          owner_nxt = OWN_DBUS;
        else if (wb_ibus_cyc)
          owner_nxt = OWN_IBUS;
      end
      OWN_IBUS: if (!wb_ibus_cyc) owner_nxt = OWN_NONE;
      OWN_DBUS: if (!wb_dbus_cyc) owner_nxt = OWN_NONE;
      default:  owner_nxt = OWN_NONE;
    endcase
  end

  // last_dbus = 0 means the last grant went to ibus, so dbus wins the first tie.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      owner     <= OWN_NONE;
      last_dbus <= 1'b0;
    end else begin
      owner <= owner_nxt;
      if (owner == OWN_NONE && owner_nxt != OWN_NONE)
        last_dbus <= (owner_nxt == OWN_DBUS);
    end
  end

  // Owner-side mux; ibus is a read-only master
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    case (owner)
      OWN_IBUS: begin
        own_cyc = wb_ibus_cyc;
        own_stb = wb_ibus_stb;
        own_adr = wb_ibus_adr;
        own_sel = 4'b1111;
      end
      OWN_DBUS: begin
        own_cyc = wb_dbus_cyc;
        own_stb = wb_dbus_stb;
        own_we  = wb_dbus_we;
        own_adr = wb_dbus_adr;
        own_dat = wb_dbus_dat;
        own_sel = wb_dbus_sel;
      end
      default: ;
    endcase
  end

  assign wbs_adr = own_adr;
  assign wbs_dat = own_dat;
  assign wbs_sel = own_sel;
  assign wbs_we  = own_we;

  // Scan from the top index down so that the lowest matching slave wins.
  always_comb begin
    hit_any = 1'b0;
    slv_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((own_adr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit_any = 1'b1;
        slv_idx = i[IW-1:0];
      end
    end
  end

  always_comb begin
    wbs_cyc = '0;
    wbs_stb = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (hit_any && slv_idx == i[IW-1:0]) begin
        wbs_cyc[i] = own_cyc;
        wbs_stb[i] = own_stb & ~to_fire;
      end
    end
  end

  // A decode miss gets a single err cycle. The ~miss_err_q term keeps the
  // pulse one cycle wide even if the master is slow to drop stb.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst)
      miss_err_q <= 1'b0;
    else
      miss_err_q <= own_stb & ~hit_any & ~miss_err_q;
  end

`ifdef WB_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;

  assign to_fire = own_stb && (to_cnt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst)
      to_cnt <= '0;
    else if (own_stb && !ack_int && !err_int)
      to_cnt <= to_cnt + 1'b1;
    else
      to_cnt <= '0;
  end
`else
  assign to_fire = 1'b0;
`endif

  // A slave ack only counts while the owner is strobing that slave; a timeout
  // masks the ack so that ack and err are never high together.
  assign rdt_sel = hit_any ? wbs_rdt[32*slv_idx +: 32] : 32'h0;
  assign ack_int = own_stb & hit_any & wbs_ack[slv_idx] & ~to_fire;
  assign err_int = miss_err_q | to_fire;

  assign wb_ibus_ack = (owner == OWN_IBUS) & ack_int;
  assign wb_ibus_err = (owner == OWN_IBUS) & err_int;
  assign wb_ibus_rdt = (owner == OWN_IBUS) ? rdt_sel : 32'h0;
  assign wb_dbus_ack = (owner == OWN_DBUS) & ack_int;
  assign wb_dbus_err = (owner == OWN_DBUS) & err_int;
  assign wb_dbus_rdt = (owner == OWN_DBUS) ? rdt_sel : 32'h0;

endmodule
